// File: rtl/fb_rxstatem.sv
// Receive nibble state machine: preamble/SoC detection, byte assembly and frame end/abort strobes.
// Optional CRC-8 check over the data bytes is built when FB_RX_CRC8_CHECK_EN is defined.
module fb_rxstatem (
    input  logic       MRxClk,
    input  logic       Reset,
    input  logic       MRxDV,
    input  logic [3:0] MRxD,
    input  logic [7:0] FrmLenByte,
    input  logic       FrmCrcStateEnd,
    output logic       StateIdle,
    output logic       StateFFS,
    output logic       StatePreamble,
    output logic [1:0] StateData,
    output logic       StateFrmCrc,
    output logic       StateDrop,
    output logic       MRxDEqDataSoC,
    output logic       RxValid,
    output logic [7:0] RxByte,
    output logic       RxEndFrm,
    output logic       RxAbort,
    output logic       RxCrcError
);

    typedef enum logic [6:0] {
        StIdle     = 7'b0000001,
        StFfs      = 7'b0000010,
        StPreamble = 7'b0000100,
        StData0    = 7'b0001000,
        StData1    = 7'b0010000,
        StFrmCrc   = 7'b0100000,
        StDrop     = 7'b1000000
    } state_e;

    state_e     stateQ, stateD;

    logic [7:0] lenQ;
    logic [7:0] byteCntQ;
    logic [7:0] lenMinusOne;
    logic [3:0] dataLowQ;
    logic [7:0] rxByteQ;
    logic       rxValidQ;
    logic       rxEndFrmQ;
    logic       rxAbortQ;

    logic       socHit;
    logic       lowNibEn;
    logic       byteDone;
    logic       lastByte;
    logic       frmEnd;
    logic       dropEntry;

    // Length 0 wraps to 255 here, so a zero length yields 256 bytes.
    assign lenMinusOne = lenQ - 8'd1;
    assign lastByte    = (byteCntQ == lenMinusOne);

    // State register
    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic; loss of MRxDV mid-frame overrides every other transition.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (MRxDV && (MRxD == 4'hF)) stateD = StFfs;
            end
            StFfs: begin
                stateD = (MRxDV && (MRxD == 4'h5)) ? StPreamble : StDrop;
            end
            StPreamble: begin
                if (!MRxDV)                stateD = StDrop;
                else if (MRxD == 4'h5)     stateD = StPreamble;
                else if (MRxD == 4'hD)     stateD = StData0;
                else                       stateD = StDrop;
            end
            StData0: begin
                stateD = MRxDV ? StData1 : StDrop;
            end
            StData1: begin
                if (!MRxDV)                stateD = StDrop;
                else if (lastByte)         stateD = StFrmCrc;
                else                       stateD = StData0;
            end
            StFrmCrc: begin
                if (!MRxDV)                stateD = StDrop;
                else if (FrmCrcStateEnd)   stateD = StIdle;
            end
            StDrop: begin
                if (!MRxDV)                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    // State flags and datapath strobes
    always_comb begin
        StateIdle     = (stateQ == StIdle);
        StateFFS      = (stateQ == StFfs);
        StatePreamble = (stateQ == StPreamble);
        StateData     = {(stateQ == StData1), (stateQ == StData0)};
        StateFrmCrc   = (stateQ == StFrmCrc);
        StateDrop     = (stateQ == StDrop);
        MRxDEqDataSoC = MRxDV && (MRxD == 4'hD);
        socHit        = (stateQ == StPreamble) && MRxDEqDataSoC;
        lowNibEn      = (stateQ == StData0) && MRxDV;
        byteDone      = (stateQ == StData1) && MRxDV;
        frmEnd        = (stateQ == StFrmCrc) && MRxDV && FrmCrcStateEnd;
        dropEntry     = (stateD == StDrop) && (stateQ != StDrop);
    end

    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            lenQ     <= 8'h00;
            byteCntQ <= 8'h00;
        end else if (socHit) begin
            lenQ     <= FrmLenByte;
            byteCntQ <= 8'h00;
        end else if (byteDone && !lastByte) begin
            byteCntQ <= byteCntQ + 8'd1;
        end
    end

    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            dataLowQ <= 4'h0;
            rxByteQ  <= 8'h00;
        end else begin
            if (lowNibEn) dataLowQ <= MRxD;
            if (byteDone) rxByteQ  <= {MRxD, dataLowQ};
        end
    end

    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            rxValidQ  <= 1'b0;
            rxEndFrmQ <= 1'b0;
            rxAbortQ  <= 1'b0;
        end else begin
            rxValidQ  <= byteDone;
            rxEndFrmQ <= frmEnd;
            rxAbortQ  <= dropEntry;
        end
    end

    assign RxValid  = rxValidQ;
    assign RxByte   = rxByteQ;
    assign RxEndFrm = rxEndFrmQ;
    assign RxAbort  = rxAbortQ;

`ifdef FB_RX_CRC8_CHECK_EN
    logic [7:0] crcQ;
    logic [3:0] crcLowQ;
    logic       crcErrQ;

    // CRC-8, polynomial x^8+x^2+x+1, MSB first.
    function automatic logic [7:0] crc8Byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            crcQ    <= 8'h00;
            crcLowQ <= 4'h0;
            crcErrQ <= 1'b0;
        end else begin
            if (socHit)        crcQ <= 8'h00;
            else if (byteDone) crcQ <= crc8Byte(crcQ, {MRxD, dataLowQ});
            if ((stateQ == StFrmCrc) && MRxDV && !FrmCrcStateEnd) crcLowQ <= MRxD;
            crcErrQ <= frmEnd && (crcQ != {MRxD, crcLowQ});
        end
    end

    assign RxCrcError = crcErrQ;
`else
    assign RxCrcError = 1'b0;
`endif

    stateOneHot: assert property (@(posedge MRxClk) disable iff (Reset) $onehot(stateQ));
    endAbortExcl: assert property (@(posedge MRxClk) disable iff (Reset) !(RxEndFrm && RxAbort));

endmodule

// File: tb/tb_fb_rxstatem.sv
// Scoreboard bench for fb_rxstatem: stimulus pushes expected pulses, a negedge monitor pops them.
module tb_fb_rxstatem;

    logic       MRxClk = 1'b0;
    logic       Reset;
    logic       MRxDV;
    logic [3:0] MRxD;
    logic [7:0] FrmLenByte;
    logic       FrmCrcStateEnd;
    logic       StateIdle, StateFFS, StatePreamble, StateFrmCrc, StateDrop;
    logic [1:0] StateData;
    logic       MRxDEqDataSoC, RxValid, RxEndFrm, RxAbort, RxCrcError;
    logic [7:0] RxByte;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        logic [2:0] kind;   // {RxValid, RxEndFrm, RxAbort}
        logic [7:0] data;
        logic       crcErr;
    } exp_t;

    exp_t sbQ[$];
    logic [7:0] crcModel;

    fb_rxstatem dut (
        .MRxClk        (MRxClk),
        .Reset         (Reset),
        .MRxDV         (MRxDV),
        .MRxD          (MRxD),
        .FrmLenByte    (FrmLenByte),
        .FrmCrcStateEnd(FrmCrcStateEnd),
        .StateIdle     (StateIdle),
        .StateFFS      (StateFFS),
        .StatePreamble (StatePreamble),
        .StateData     (StateData),
        .StateFrmCrc   (StateFrmCrc),
        .StateDrop     (StateDrop),
        .MRxDEqDataSoC (MRxDEqDataSoC),
        .RxValid       (RxValid),
        .RxByte        (RxByte),
        .RxEndFrm      (RxEndFrm),
        .RxAbort       (RxAbort),
        .RxCrcError    (RxCrcError)
    );

    always #5 MRxClk = ~MRxClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] r;
        r = crc;
        for (int i = 7; i >= 0; i--) begin
            if (r[7] ^ d[i]) r = {r[6:0], 1'b0} ^ 8'h07;
            else             r = {r[6:0], 1'b0};
        end
        return r;
    endfunction

    task automatic pushExp(input logic [2:0] k, input logic [7:0] d, input logic e);
        exp_t x;
        x.kind   = k;
        x.data   = d;
        x.crcErr = e;
        sbQ.push_back(x);
    endtask

    // Drive one nibble, then advance to 1 time unit after the next rising edge.
    task automatic nib(input logic dv, input logic [3:0] d, input logic ce);
        MRxDV          = dv;
        MRxD           = d;
        FrmCrcStateEnd = ce;
        @(posedge MRxClk);
        #1;
    endtask

    task automatic startFrame(input logic [7:0] len);
        nib(1'b1, 4'hF, 1'b0);
        nib(1'b1, 4'h5, 1'b0);
        nib(1'b1, 4'h5, 1'b0);
        FrmLenByte = len;
        nib(1'b1, 4'hD, 1'b0);
        crcModel = 8'h00;
    endtask

    task automatic sendByte(input logic [7:0] b);
        nib(1'b1, b[3:0], 1'b0);
        pushExp(3'b100, b, 1'b0);
        nib(1'b1, b[7:4], 1'b0);
        crcModel = crc8(crcModel, b);
    endtask

    task automatic sendCrc(input logic [7:0] c);
        logic e;
`ifdef FB_RX_CRC8_CHECK_EN
        e = (crcModel != c);
`else
        e = 1'b0;
`endif
        nib(1'b1, c[3:0], 1'b0);
        pushExp(3'b010, 8'h00, e);
        nib(1'b1, c[7:4], 1'b1);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge MRxClk) begin
        if (!Reset) begin
            if (RxCrcError && !RxEndFrm) check("crc_err_outside_end", 32'(RxCrcError), 32'd0);
            if (RxValid || RxEndFrm || RxAbort) begin
                if (sbQ.size() == 0) begin
                    check("unexpected_pulse", 32'({RxValid, RxEndFrm, RxAbort}), 32'd0);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    check("pulse_kind", 32'({RxValid, RxEndFrm, RxAbort}), 32'(e.kind));
                    if (e.kind[2]) check("rx_byte", 32'(RxByte), 32'(e.data));
                    if (e.kind[1]) check("rx_crc_error", 32'(RxCrcError), 32'(e.crcErr));
                end
            end
        end
    end

    initial begin
        Reset          = 1'b1;
        MRxDV          = 1'b0;
        MRxD           = 4'h0;
        FrmLenByte     = 8'h00;
        FrmCrcStateEnd = 1'b0;
        crcModel       = 8'h00;
        #12;
        check("reset_idle", 32'(StateIdle), 32'd1);
        check("reset_other_flags",
              32'({StateFFS, StatePreamble, StateData, StateFrmCrc, StateDrop}), 32'd0);
        check("reset_pulses", 32'({RxValid, RxEndFrm, RxAbort, RxCrcError}), 32'd0);
        check("reset_rxbyte", 32'(RxByte), 32'd0);
        @(posedge MRxClk);
        #1;
        Reset = 1'b0;

        // Combinational SoC detect
        MRxDV = 1'b1; MRxD = 4'hD; #1;
        check("soc_eq_hit", 32'(MRxDEqDataSoC), 32'd1);
        MRxD = 4'hC; #1;
        check("soc_eq_wrong_nib", 32'(MRxDEqDataSoC), 32'd0);
        MRxDV = 1'b0; MRxD = 4'hD; #1;
        check("soc_eq_no_dv", 32'(MRxDEqDataSoC), 32'd0);
        nib(1'b0, 4'h0, 1'b0);
        check("idle_stays", 32'(StateIdle), 32'd1);

        // Single-byte frame, nibbles 3,4 -> 0x43
        startFrame(8'd1);
        check("soc_to_data0", 32'(StateData), 32'b01);
        nib(1'b1, 4'h3, 1'b0);
        check("data0_to_data1", 32'(StateData), 32'b10);
        pushExp(3'b100, 8'h43, 1'b0);
        nib(1'b1, 4'h4, 1'b0);
        crcModel = crc8(crcModel, 8'h43);
        check("len1_to_frmcrc", 32'(StateFrmCrc), 32'd1);
        nib(1'b1, 4'h1, 1'b0);
        check("frmcrc_cycle2", 32'(StateFrmCrc), 32'd1);
`ifdef FB_RX_CRC8_CHECK_EN
        pushExp(3'b010, 8'h00, crcModel != 8'h21);
`else
        pushExp(3'b010, 8'h00, 1'b0);
`endif
        nib(1'b1, 4'h2, 1'b1);
        check("frmcrc_to_idle", 32'(StateIdle), 32'd1);
        nib(1'b0, 4'h0, 1'b0);

        // FFS followed by a bad nibble
        nib(1'b1, 4'hF, 1'b0);
        check("idle_to_ffs", 32'(StateFFS), 32'd1);
        pushExp(3'b001, 8'h00, 1'b0);
        nib(1'b1, 4'h7, 1'b0);
        check("ffs_bad_to_drop", 32'(StateDrop), 32'd1);
        nib(1'b1, 4'h3, 1'b0);
        check("drop_holds", 32'(StateDrop), 32'd1);
        nib(1'b0, 4'h0, 1'b0);
        check("drop_to_idle", 32'(StateIdle), 32'd1);

        // Bad preamble nibble
        nib(1'b1, 4'hF, 1'b0);
        nib(1'b1, 4'h5, 1'b0);
        check("ffs_to_preamble", 32'(StatePreamble), 32'd1);
        pushExp(3'b001, 8'h00, 1'b0);
        nib(1'b1, 4'hA, 1'b0);
        check("preamble_bad_to_drop", 32'(StateDrop), 32'd1);
        nib(1'b0, 4'h0, 1'b0);

        // MRxDV lost in Data1 of byte 3: two bytes, then abort
        startFrame(8'd8);
        sendByte(8'hA5);
        sendByte(8'h3C);
        nib(1'b1, 4'h9, 1'b0);
        pushExp(3'b001, 8'h00, 1'b0);
        nib(1'b0, 4'h6, 1'b0);
        check("dv_loss_to_drop", 32'(StateDrop), 32'd1);
        nib(1'b0, 4'h0, 1'b0);
        check("dv_loss_back_idle", 32'(StateIdle), 32'd1);

        // Length 0 -> 256 bytes
        startFrame(8'd0);
        for (int i = 0; i < 256; i++) begin
            sendByte(8'(i));
            if (i == 254) check("len0_no_early_exit", 32'(StateData), 32'b01);
        end
        check("len0_to_frmcrc", 32'(StateFrmCrc), 32'd1);
        sendCrc(crcModel);
        nib(1'b0, 4'h0, 1'b0);

        // CRC good / bad on data 0x01 (CRC-8 of 0x01 is 0x07)
        startFrame(8'd1);
        sendByte(8'h01);
        sendCrc(8'h07);
        nib(1'b0, 4'h0, 1'b0);
        startFrame(8'd1);
        sendByte(8'h01);
        sendCrc(8'h08);
        nib(1'b0, 4'h0, 1'b0);

        // Reset in Data0 discards the frame silently
        startFrame(8'd4);
        check("pre_reset_data0", 32'(StateData), 32'b01);
        MRxDV = 1'b0;
        Reset = 1'b1;
        #1;
        check("async_reset_idle", 32'(StateIdle), 32'd1);
        check("async_reset_data", 32'(StateData), 32'd0);
        @(posedge MRxClk);
        #1;
        Reset = 1'b0;
        nib(1'b0, 4'h0, 1'b0);

        // Reception resumes after reset
        startFrame(8'd2);
        sendByte(8'h5A);
        sendByte(8'hC3);
        sendCrc(crcModel);
        nib(1'b0, 4'h0, 1'b0);

        repeat (4) nib(1'b0, 4'h0, 1'b0);
        check("scoreboard_drained", 32'(sbQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
